// File: rtl/interrupt_controller.sv
// Five-source, two-level interrupt controller: arbitration, vector generation and in-service tracking.
// Define INT_NESTING_EN to let a high-priority source preempt a low-priority ISR.
module interrupt_controller #(
    parameter logic [7:0] VEC_BASE   = 8'h03,
    parameter logic [7:0] VEC_STRIDE = 8'h08
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic [4:0] irq_i,
    input  logic [7:0] ie_i,
    input  logic [4:0] ip_i,
    input  logic       boundary_i,
    input  logic       reti_i,
    input  logic       int_ack_i,
    output logic       int_o,
    output logic [7:0] int_vec_o,
    output logic [4:0] clr_flag_o,
    output logic [1:0] in_service_o
);

    typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       lvl_q, lvl_d;
    logic [7:0] vec_q, vec_d;
    logic [4:0] clr_q, clr_d;
    logic [1:0] is_q, is_d;

    logic [4:0] elig_raw, elig, hi, pick;
    logic [2:0] win_idx;
    logic       win_lvl;
    logic [7:0] win_vec;

    always_comb begin
        elig_raw = ie_i[7] ? (irq_i & ie_i[4:0]) : 5'b0;
`ifdef INT_NESTING_EN
        if (is_q[1]) begin
            elig = 5'b0;
        end else if (is_q[0]) begin
            elig = elig_raw & ip_i;
        end else begin
            elig = elig_raw;
        end
`else
        elig = (|is_q) ? 5'b0 : elig_raw;
`endif
    end

    // High-priority set wins outright; otherwise fall back to all eligible sources.
    always_comb begin
        hi      = elig & ip_i;
        win_lvl = |hi;
        pick    = win_lvl ? hi : elig;
        win_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = 3'(i);
            end
        end
        win_vec = VEC_BASE + ({5'b0, win_idx} * VEC_STRIDE);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lvl_d   = lvl_q;
        vec_d   = vec_q;
        clr_d   = 5'b0;
        is_d    = is_q;

        // RETI retires the innermost level before any new level is marked.
        if (reti_i) begin
            if (is_q[1]) begin
                is_d[1] = 1'b0;
            end else if (is_q[0]) begin
                is_d[0] = 1'b0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (boundary_i && (|elig) && !reti_i) begin
                    state_d = StReq;
                    idx_d   = win_idx;
                    lvl_d   = win_lvl;
                    vec_d   = win_vec;
                end
            end
            StReq: begin
                if (int_ack_i) begin
                    state_d     = StAck;
                    is_d[lvl_q] = 1'b1;
                    if (idx_q != 3'd4) begin
                        clr_d[idx_q] = 1'b1;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            lvl_q   <= 1'b0;
            vec_q   <= 8'h00;
            clr_q   <= 5'b0;
            is_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            vec_q   <= vec_d;
            clr_q   <= clr_d;
            is_q    <= is_d;
        end
    end

    assign int_o        = (state_q == StReq);
    assign int_vec_o    = vec_q;
    assign clr_flag_o   = clr_q;
    assign in_service_o = is_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expected vectors and acks,
// a negedge monitor pops and compares them as the DUT raises int or pulses clr_flag.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] irq;
    logic [7:0] ie;
    logic [4:0] ip;
    logic       boundary, reti, int_ack;
    logic       int_o;
    logic [7:0] int_vec;
    logic [4:0] clr_flag;
    logic [1:0] in_service;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_vec_q[$];
    logic [6:0] exp_ack_q[$];
    logic       int_prev = 1'b0;

    interrupt_controller dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .irq_i        (irq),
        .ie_i         (ie),
        .ip_i         (ip),
        .boundary_i   (boundary),
        .reti_i       (reti),
        .int_ack_i    (int_ack),
        .int_o        (int_o),
        .int_vec_o    (int_vec),
        .clr_flag_o   (clr_flag),
        .in_service_o (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [7:0] v);
        exp_vec_q.push_back(v);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        chk("int_latency", int_o, 1);
    endtask

    task automatic ack(input logic [4:0] clr, input logic [1:0] is);
        exp_ack_q.push_back({clr, is});
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("int_drop_after_ack", int_o, 0);
        tick();
    endtask

    task automatic reti_pulse(input string name, input logic [1:0] is_exp);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk(name, in_service, is_exp);
    endtask

    // Monitor: compare whenever int rises or a clear pulse appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (int_o && !int_prev) begin
                if (exp_vec_q.size() == 0) begin
                    chk("unexpected_int", 1, 0);
                end else begin
                    chk("int_vec", int_vec, exp_vec_q.pop_front());
                end
            end
            if (clr_flag != 5'b0) begin
                if (exp_ack_q.size() == 0) begin
                    chk("unexpected_clr_flag", clr_flag, 0);
                end else begin
                    chk("clr_flag+in_service", {clr_flag, in_service}, exp_ack_q.pop_front());
                end
            end
        end
        int_prev = int_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; irq = 5'b0; ie = 8'h00; ip = 5'b0;
        boundary = 1'b0; reti = 1'b0; int_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int", int_o, 0);
        chk("rst_vec", int_vec, 8'h00);
        chk("rst_clr", clr_flag, 0);
        chk("rst_is", in_service, 0);
        rst_n = 1'b1;
        tick();

        // Single source TIMER0
        ie = 8'h82; irq = 5'b00010;
        request(8'h0B);
        ack(5'b00010, 2'b01);
        irq = 5'b0;
        reti_pulse("reti_single", 2'b00);

        // Priority: SERIAL high beats EXT0 low; SERIAL gets no hardware clear
        ie = 8'h9F; irq = 5'b10001; ip = 5'b10000;
        request(8'h23);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("serial_no_clr", clr_flag, 0);
        chk("serial_is", in_service, 2'b10);
        tick();
        reti_pulse("reti_serial", 2'b00);
        ip = 5'b0;
        request(8'h03);
        ack(5'b00001, 2'b01);
        irq = 5'b0;
        reti_pulse("reti_ext0", 2'b00);

        // Nesting: TIMER0 low in service, EXT1 high arrives
        ie = 8'h86; ip = 5'b0; irq = 5'b00010;
        request(8'h0B);
        ack(5'b00010, 2'b01);
        irq = 5'b00100; ip = 5'b00100;
`ifdef INT_NESTING_EN
        request(8'h13);
        ack(5'b00100, 2'b11);
        irq = 5'b0;
        reti_pulse("reti_nest_hi", 2'b01);
        reti_pulse("reti_nest_lo", 2'b00);
`else
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        chk("no_nest_int", int_o, 0);
        irq = 5'b0;
        reti_pulse("reti_no_nest", 2'b00);
`endif
        reti_pulse("reti_idle_noop", 2'b00);

        // Stability: vector held while inputs change during REQ
        ie = 8'h82; ip = 5'b0; irq = 5'b00010;
        request(8'h0B);
        irq = 5'b0; ie = 8'h00; ip = 5'b11111;
        repeat (3) tick();
        chk("hold_int", int_o, 1);
        chk("hold_vec", int_vec, 8'h0B);
        ack(5'b00010, 2'b01);
        chk("idle_vec_kept", int_vec, 8'h0B);
        reti_pulse("reti_hold", 2'b00);

        // Gating
        ie = 8'h1F; irq = 5'b11111; boundary = 1'b1; ip = 5'b0;
        repeat (3) tick();
        chk("gate_ea", int_o, 0);
        ie = 8'h9F; boundary = 1'b0;
        repeat (3) tick();
        chk("gate_boundary", int_o, 0);
        boundary = 1'b1; reti = 1'b1;
        tick();
        boundary = 1'b0; reti = 1'b0;
        chk("gate_reti", int_o, 0);

        // Stray int_ack in IDLE is ignored
        irq = 5'b0; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("stray_ack_clr", clr_flag, 0);
        chk("stray_ack_is", in_service, 0);
        tick();

        // Reset mid-REQ drops int asynchronously
        irq = 5'b00100; boundary = 1'b1;
        tick();
        boundary = 1'b0;
        chk("pre_rst_int", int_o, 1);
        chk("pre_rst_vec", int_vec, 8'h13);
        int_prev = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midreq_rst_int", int_o, 0);
        chk("midreq_rst_vec", int_vec, 8'h00);
        chk("midreq_rst_is", in_service, 0);
        int_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        int_ack = 1'b0;
        irq = 5'b0;
        repeat (2) tick();
        chk("post_rst_clr", clr_flag, 0);
        chk("post_rst_int", int_o, 0);

        chk("vec_queue_drained", exp_vec_q.size(), 0);
        chk("ack_queue_drained", exp_ack_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter VEC_BASE, default 8'h03: vector of source 0.
REQ-002 SHALL have parameter VEC_STRIDE, default 8'h08: vector spacing between sources.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port irq, input, 5: source flags [0]=EXT0, [1]=TIMER0, [2]=EXT1, [3]=TIMER1, [4]=SERIAL; level-sensitive.
REQ-006 SHALL have port ie, input, 8: enables; [7]=EA global, [4:0] per-source.
REQ-007 SHALL have port ip, input, 5: per-source priority; 1=high, 0=low.
REQ-008 SHALL have port boundary, input, 1: program counter can accept an interrupt this cycle.
REQ-009 SHALL have port reti, input, 1: one-cycle pulse; RETI executed.
REQ-010 SHALL have port int_ack, input, 1: program counter accepted the vector.
REQ-011 SHALL have port int, output, 1: interrupt request to program counter.
REQ-012 SHALL have port int_vec, output, 8: vector address to program counter.
REQ-013 SHALL have port clr_flag, output, 5: one-cycle hardware clear pulse per source.
REQ-014 SHALL have port in_service, output, 2: [1]=high level active, [0]=low level active.

Function
REQ-015 SHALL use a three-state FSM: IDLE, REQ, ACK.
REQ-016 Eligible set SHALL be irq & ie[4:0], gated by ie[7]=1.
REQ-017 Eligible set SHALL be masked by level: in_service[1]=1 blocks all; in_service[0]=1 admits only ip=1 sources (see REQ-031).
REQ-018 Winner SHALL be: any high-priority eligible before any low; within a level, lowest index wins.
REQ-019 IDLE->REQ SHALL occur on a rising edge with boundary=1, an eligible source present, and reti=0.
REQ-020 On entering REQ, winner index and level SHALL be latched; int_vec = VEC_BASE + index*VEC_STRIDE (8-bit, wraps mod 256).
REQ-021 In REQ, int SHALL be 1 and int_vec SHALL be held stable until int_ack=1, even if irq, ie or ip change.
REQ-022 REQ->ACK SHALL occur on the edge where int_ack=1; int SHALL be 0 from the following cycle.
REQ-023 In ACK, the latched level's in_service bit SHALL be set and clr_flag[index] pulsed for one cycle; no clr_flag for index 4 (SERIAL cleared by software).
REQ-024 ACK->IDLE SHALL be unconditional after one cycle; int_vec SHALL keep its last value in IDLE.
REQ-025 int_ack received while not in REQ SHALL be ignored.
REQ-026 reti SHALL clear in_service[1] if set, else in_service[0]; reti with both 0 SHALL have no effect.
REQ-027 reti coinciding with ACK SHALL clear first, then set the new bit in the same edge.
REQ-028 Default interrupt latency: boundary-to-int 1 cycle; int_ack-to-clr_flag 1 cycle.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, int=0, int_vec=8'h00, clr_flag=0, in_service=2'b00, latched index/level=0.
REQ-030 Reset asserted in REQ SHALL drop int immediately; no clr_flag or in_service update SHALL follow.

Configuration
REQ-031 Macro INT_NESTING_EN defined: behaviour per REQ-017 (high preempts low ISR); undefined: any in_service bit set blocks all arbitration and in_service[1:0] may never both be 1.

Verification
REQ-032 Reset: reset=0 mid-REQ -> int=0 same cycle, int_vec=8'h00, in_service=0.
REQ-033 Single source: ie=8'h82, irq=5'b00010, boundary=1 -> int=1, int_vec=8'h0B; int_ack -> clr_flag=5'b00010, in_service=2'b01.
REQ-034 Priority: ie=8'h9F, irq=5'b10001, ip=5'b10000 -> int_vec=8'h23; ip=0 -> int_vec=8'h03.
REQ-035 Nesting: TIMER0 low in service, EXT1 (ip[2]=1) asserted -> int_vec=8'h13, in_service=2'b11 with INT_NESTING_EN; no int without it.
REQ-036 Stability/RETI: irq drops while int=1 -> int_vec held until int_ack; reti with in_service=2'b11 -> 2'b01, next reti -> 2'b00.
REQ-037 Gating: ie[7]=0 with irq=5'b11111 -> int stays 0; boundary=0 -> int stays 0.
